// File: rtl/icache_refill_controller_pkg.sv
// ============================================================================
// Module      : icache_refill_controller_pkg
// Description : Shared fetch-unit types for the I-cache refill path: refill
//               FSM state encoding, default cache geometry, index/tag path
//               typedefs and address-split helpers also used by FetchStage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_refill_controller_pkg;

  localparam int ICACHE_LINE_BEATS   = 4;
  localparam int ICACHE_INDEX_WIDTH  = 6;
  localparam int ICACHE_ADDR_WIDTH   = 32;
  localparam int ICACHE_DATA_WIDTH   = 32;
  localparam int ICACHE_OFFSET_WIDTH = $clog2(ICACHE_LINE_BEATS * ICACHE_DATA_WIDTH / 8);
  localparam int ICACHE_TAG_WIDTH    = ICACHE_ADDR_WIDTH - ICACHE_INDEX_WIDTH - ICACHE_OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IC_IDLE      = 2'd0,
    IC_REQ       = 2'd1,
    IC_WAIT_DATA = 2'd2,
    IC_DONE      = 2'd3
  } IcRefillState;

  typedef logic [ICACHE_INDEX_WIDTH-1:0] IcacheIndexPath;
  typedef logic [ICACHE_TAG_WIDTH-1:0]   IcacheTagPath;

  // Set index of a physical fetch address for the default geometry
  function automatic IcacheIndexPath ToIcacheIndex(input logic [ICACHE_ADDR_WIDTH-1:0] addr);
    return addr[ICACHE_OFFSET_WIDTH +: ICACHE_INDEX_WIDTH];
  endfunction

  // Tag of a physical fetch address for the default geometry
  function automatic IcacheTagPath ToIcacheTag(input logic [ICACHE_ADDR_WIDTH-1:0] addr);
    return addr[ICACHE_ADDR_WIDTH-1 -: ICACHE_TAG_WIDTH];
  endfunction

endpackage

`default_nettype wire

// File: rtl/icache_refill_beat_counter.sv
// ============================================================================
// Module      : icache_refill_beat_counter
// Description : Beat slot counter for one line refill, with synchronous
//               clear and last-beat detect. Wraps naturally after the last
//               beat since LINE_BEATS is a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_beat_counter #(
  parameter int LINE_BEATS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          inc,
  output logic [$clog2(LINE_BEATS)-1:0] count,
  output logic                          last
);

  localparam int BEAT_WIDTH = $clog2(LINE_BEATS);

  logic [BEAT_WIDTH-1:0] r_count;

  // Count accepted beats; clear has priority so a new refill starts at slot 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + BEAT_WIDTH'(1);
    end
  end

  assign count = r_count;
  assign last  = (r_count == BEAT_WIDTH'(LINE_BEATS - 1));

endmodule

`default_nettype wire

// File: rtl/icache_refill_controller.sv
// ============================================================================
// Module      : icache_refill_controller
// Description : Sequences I-cache line refills: takes a fetch miss, issues
//               one line-aligned memory read, writes LINE_BEATS response
//               beats into the data array, writes tag/valid on the last beat
//               and pulses refillDone. A flush during the data phase still
//               installs the line but suppresses refillDone.
//               Optional macro ICACHE_REFILL_PERF_EN adds saturating
//               perfRefillCount / perfMissCycles counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill_controller
  import icache_refill_controller_pkg::*;
#(
  parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH  = ICACHE_DATA_WIDTH,
  parameter int LINE_BEATS  = ICACHE_LINE_BEATS,
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          missValid,
  input  logic [ADDR_WIDTH-1:0]         missAddr,
  input  logic                          flush,
  output logic                          memReqValid,
  input  logic                          memReqReady,
  output logic [ADDR_WIDTH-1:0]         memReqAddr,
  input  logic                          memRspValid,
  input  logic [DATA_WIDTH-1:0]         memRspData,
  output logic                          cacheWE,
  output logic [INDEX_WIDTH-1:0]        cacheWIndex,
  output logic [$clog2(LINE_BEATS)-1:0] cacheWBeat,
  output logic [DATA_WIDTH-1:0]         cacheWData,
  output logic                          cacheTagWE,
  output logic [ADDR_WIDTH-INDEX_WIDTH-$clog2(LINE_BEATS*DATA_WIDTH/8)-1:0] cacheTag,
  output logic                          refillDone,
  output logic                          busy
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]                   perfRefillCount,
  output logic [31:0]                   perfMissCycles
`endif
);

  localparam int OFFSET_WIDTH = $clog2(LINE_BEATS * DATA_WIDTH / 8);
  localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int BEAT_WIDTH   = $clog2(LINE_BEATS);
  localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_WIDTH) - ADDR_WIDTH'(1));

  IcRefillState          r_state;
  IcRefillState          w_state_next;
  logic [ADDR_WIDTH-1:0] r_line_addr;
  logic                  r_cancelled;
  logic                  w_latch;
  logic                  w_clear_cnt;
  logic                  w_beat;
  logic [BEAT_WIDTH-1:0] w_count;
  logic                  w_last;

  icache_refill_beat_counter #(
    .LINE_BEATS(LINE_BEATS)
  ) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear_cnt),
    .inc   (w_beat),
    .count (w_count),
    .last  (w_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IC_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Line address capture and sticky cancel for flushes seen during the data phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line_addr <= '0;
      r_cancelled <= 1'b0;
    end else begin
      if (w_latch) begin
        r_line_addr <= missAddr & c_LINE_MASK;
      end
      if (r_state == IC_DONE) begin
        r_cancelled <= 1'b0;
      end else if ((r_state == IC_WAIT_DATA) && flush) begin
        r_cancelled <= 1'b1;
      end
    end
  end

  // Next-state and control outputs; a flush with a same-cycle handshake still commits
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_clear_cnt  = 1'b0;
    w_beat       = 1'b0;
    memReqValid  = 1'b0;
    cacheWE      = 1'b0;
    cacheTagWE   = 1'b0;
    refillDone   = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IC_IDLE: begin
        busy = 1'b0;
        if (missValid && !flush) begin
          w_latch      = 1'b1;
          w_state_next = IC_REQ;
        end
      end
      IC_REQ: begin
        memReqValid = 1'b1;
        if (memReqReady) begin
          w_clear_cnt  = 1'b1;
          w_state_next = IC_WAIT_DATA;
        end else if (flush) begin
          w_state_next = IC_IDLE;
        end
      end
      IC_WAIT_DATA: begin
        if (memRspValid) begin
          w_beat  = 1'b1;
          cacheWE = 1'b1;
          if (w_last) begin
            cacheTagWE   = 1'b1;
            w_state_next = IC_DONE;
          end
        end
      end
      IC_DONE: begin
        refillDone   = !r_cancelled;
        w_state_next = IC_IDLE;
      end
      default: begin
        w_state_next = IC_IDLE;
      end
    endcase
  end

  assign memReqAddr  = r_line_addr;
  assign cacheWIndex = r_line_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cacheTag    = r_line_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign cacheWBeat  = w_count;
  assign cacheWData  = cacheWE ? memRspData : '0;

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] r_perf_refills;
  logic [31:0] r_perf_cycles;

  // Saturating completion and busy-cycle counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_refills <= '0;
      r_perf_cycles  <= '0;
    end else begin
      if ((r_state == IC_DONE) && (r_perf_refills != '1)) begin
        r_perf_refills <= r_perf_refills + 32'd1;
      end
      if (busy && (r_perf_cycles != '1)) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
    end
  end

  assign perfRefillCount = r_perf_refills;
  assign perfMissCycles  = r_perf_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_refill_controller.sv
// ============================================================================
// Module      : tb_icache_refill_controller
// Description : Self-checking bench for icache_refill_controller. A
//               transaction-level model (request pending / beats remaining /
//               completion pending) predicts every output each cycle; directed
//               scenarios add literal expectations, followed by random traffic.
//               Honours ICACHE_REFILL_PERF_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_refill_controller;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LB = 4;
  localparam int IW = 6;
  localparam int LINE_BYTES = LB * DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          missValid;
  logic [AW-1:0] missAddr;
  logic          flush;
  logic          memReqValid;
  logic          memReqReady;
  logic [AW-1:0] memReqAddr;
  logic          memRspValid;
  logic [DW-1:0] memRspData;
  logic          cacheWE;
  logic [IW-1:0] cacheWIndex;
  logic [1:0]    cacheWBeat;
  logic [DW-1:0] cacheWData;
  logic          cacheTagWE;
  logic [21:0]   cacheTag;
  logic          refillDone;
  logic          busy;
`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0]   perfRefillCount;
  logic [31:0]   perfMissCycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_refill_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_BEATS(LB), .INDEX_WIDTH(IW)
  ) dut (
    .clk(clk), .rst(rst), .missValid(missValid), .missAddr(missAddr), .flush(flush),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
    .memRspValid(memRspValid), .memRspData(memRspData),
    .cacheWE(cacheWE), .cacheWIndex(cacheWIndex), .cacheWBeat(cacheWBeat),
    .cacheWData(cacheWData), .cacheTagWE(cacheTagWE), .cacheTag(cacheTag),
    .refillDone(refillDone), .busy(busy)
`ifdef ICACHE_REFILL_PERF_EN
    , .perfRefillCount(perfRefillCount), .perfMissCycles(perfMissCycles)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_req;      // a request is waiting for its handshake
  int            m_left;     // beats still owed for the accepted request
  bit            m_done;     // completion cycle is next
  bit            m_cancel;   // fetch flushed while beats were outstanding
  logic [AW-1:0] m_addr;
  longint        m_refills;
  longint        m_cycles;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req <= 0; m_left <= 0; m_done <= 0; m_cancel <= 0;
      m_addr <= '0; m_refills <= 0; m_cycles <= 0;
    end else begin
      if (m_req || m_left > 0 || m_done) m_cycles <= m_cycles + 1;
      if (m_done) begin
        m_done <= 0; m_cancel <= 0; m_refills <= m_refills + 1;
      end else if (m_left > 0) begin
        if (flush) m_cancel <= 1;
        if (memRspValid) begin
          m_left <= m_left - 1;
          if (m_left == 1) m_done <= 1;
        end
      end else if (m_req) begin
        if (memReqReady) begin
          m_req <= 0; m_left <= LB;
        end else if (flush) begin
          m_req <= 0;
        end
      end else if (missValid && !flush) begin
        m_req  <= 1;
        m_addr <= missAddr - (missAddr % LINE_BYTES);
      end
    end
  end

  // Event counters used by directed scenarios
  int hs_count = 0;
  int we_count = 0;
  int done_count = 0;
  always @(posedge clk) begin
    if (rst && memReqValid && memReqReady) hs_count <= hs_count + 1;
    if (rst && cacheWE) we_count <= we_count + 1;
    if (rst && refillDone) done_count <= done_count + 1;
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin : cmp
    bit exp_we;
    exp_we = (m_left > 0) && memRspValid;
    chk("busy", busy, (m_req || m_left > 0 || m_done));
    chk("memReqValid", memReqValid, m_req);
    if (m_req) chk("memReqAddr", memReqAddr, m_addr);
    chk("cacheWE", cacheWE, exp_we);
    if (exp_we) begin
      chk("cacheWBeat", cacheWBeat, LB - m_left);
      chk("cacheWData", cacheWData, memRspData);
      chk("cacheWIndex", cacheWIndex, (m_addr / LINE_BYTES) % (1 << IW));
    end
    chk("cacheTagWE", cacheTagWE, exp_we && (m_left == 1));
    if (exp_we && m_left == 1) chk("cacheTag", cacheTag, m_addr >> 10);
    chk("refillDone", refillDone, m_done && !m_cancel);
`ifdef ICACHE_REFILL_PERF_EN
    chk("perfRefillCount", perfRefillCount, m_refills);
    chk("perfMissCycles", perfMissCycles, m_cycles);
`endif
  end

  // Drive one cycle of inputs just after the rising edge; return at the falling edge
  task automatic drive(input bit mv, input logic [AW-1:0] ma, input bit fl,
                       input bit rdy, input bit rv, input logic [DW-1:0] rd);
    @(posedge clk); #1;
    missValid = mv; missAddr = ma; flush = fl;
    memReqReady = rdy; memRspValid = rv; memRspData = rd;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, we0, done0;
    logic [31:0] pr0;
    rst = 1'b1;
    missValid = 0; missAddr = '0; flush = 0;
    memReqReady = 0; memRspValid = 0; memRspData = '0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_reqvalid", memReqValid, 0);
    chk("reset_reqaddr", memReqAddr, 0);
    chk("reset_we", cacheWE, 0);
    chk("reset_beat", cacheWBeat, 0);
    chk("reset_done", refillDone, 0);
    @(negedge clk) rst = 1'b1;

    // Basic refill, zero-wait memory
    drive(1, 32'h0000_1234, 0, 1, 0, 0);
    chk("t1_idle_busy", busy, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("t1_reqvalid", memReqValid, 1);
    chk("t1_reqaddr", memReqAddr, 32'h0000_1230);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 32'hA0 + i);
      chk("t1_we", cacheWE, 1);
      chk("t1_beat", cacheWBeat, i);
      chk("t1_data", cacheWData, 32'hA0 + i);
      chk("t1_index", cacheWIndex, 6'h23);
      chk("t1_tagwe", cacheTagWE, (i == 3));
    end
    chk("t1_tag", cacheTag, 22'h4);
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_done", refillDone, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_done_pulse", refillDone, 0);
    chk("t1_idle_after", busy, 0);

    // Request backpressure: ready low three cycles
    hs0 = hs_count;
    drive(1, 32'h0000_8008, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("t2_hold_valid", memReqValid, 1);
      chk("t2_hold_addr", memReqAddr, 32'h0000_8000);
    end
    drive(0, 0, 0, 1, 0, 0);
    chk("t2_hold_valid4", memReqValid, 1);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, $urandom);
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_done", refillDone, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_one_handshake", hs_count - hs0, 1);

    // Flush in REQ before ready
    hs0 = hs_count; we0 = we_count; done0 = done_count;
    drive(1, 32'h0000_2040, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h5);
    chk("t3_idle", busy, 0);
    chk("t3_noreq", memReqValid, 0);
    repeat (3) drive(0, 0, 0, 0, 1, 32'h6);
    chk("t3_no_hs", hs_count - hs0, 0);
    chk("t3_no_we", we_count - we0, 0);
    chk("t3_no_done", done_count - done0, 0);

    // Flush during data phase after beat 1
    done0 = done_count;
`ifdef ICACHE_REFILL_PERF_EN
    pr0 = perfRefillCount;
`else
    pr0 = '0;
`endif
    drive(1, 32'h0000_3000, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 32'hB0);
    drive(0, 0, 0, 0, 1, 32'hB1);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'hB2);
    chk("t4_we_after_flush", cacheWE, 1);
    drive(0, 0, 0, 0, 1, 32'hB3);
    chk("t4_tagwe", cacheTagWE, 1);
    chk("t4_beat3", cacheWBeat, 3);
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_done_cycle_busy", busy, 1);
    chk("t4_no_done", refillDone, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_no_done_count", done_count - done0, 0);
`ifdef ICACHE_REFILL_PERF_EN
    chk("t4_perf_refill", perfRefillCount - pr0, 1);
`endif

    // Gapped beats, missValid held through DONE
    hs0 = hs_count; we0 = we_count; done0 = done_count;
    drive(1, 32'h0000_4440, 0, 1, 0, 0);
    drive(1, 32'h0000_4440, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      bit v;
      v = (i == 0 || i == 3 || i == 5 || i == 6);
      drive(1, 32'h0000_4440, 0, 0, v, 32'hC0 + i);
      chk("t5_we_gap", cacheWE, v);
    end
    drive(1, 32'h0000_4440, 0, 0, 0, 0);
    chk("t5_done", refillDone, 1);
    drive(0, 0, 0, 1, 0, 0);
    chk("t5_idle", busy, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t5_one_handshake", hs_count - hs0, 1);
    chk("t5_four_writes", we_count - we0, 4);

    // Asynchronous reset in the middle of the data phase
    drive(1, 32'h0000_6000, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h11);
    @(posedge clk); #1;
    memRspValid = 1; memRspData = 32'h22; missValid = 0; memReqReady = 0;
    #2 rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_we", cacheWE, 0);
    chk("t6_tagwe", cacheTagWE, 0);
    chk("t6_data", cacheWData, 0);
    chk("t6_beat", cacheWBeat, 0);
    chk("t6_reqaddr", memReqAddr, 0);
    chk("t6_index", cacheWIndex, 0);
    chk("t6_tag", cacheTag, 0);
    @(posedge clk); #1;
    memRspValid = 0; rst = 1'b1;
    drive(1, 32'h0000_7770, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("t6_req_after", memReqValid, 1);
    chk("t6_reqaddr_after", memReqAddr, 32'h0000_7770);
    drive(0, 0, 0, 0, 1, 32'hD0);
    chk("t6_beat0", cacheWBeat, 0);
    for (int i = 1; i < 4; i++) drive(0, 0, 0, 0, 1, 32'hD0 + i);
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_done", refillDone, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 3), $urandom, ($urandom_range(0, 9) == 0),
            $urandom_range(0, 1), ($urandom_range(0, 9) < 6), $urandom);
    end
    repeat (4) drive(0, 0, 0, 1, 1, $urandom);
    repeat (2) drive(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_refill_controller.md
Name: icache_refill_controller

Overview:
- Sequences instruction-cache line refills for the fetch stage.
- On an I-cache miss reported by fetch, it issues one line-aligned read request to the memory side and collects LINE_BEATS response beats.
- It writes each beat into the I-cache data array, writes the tag/valid on the last beat, then signals completion so fetch can release its stall.
- It sits between FetchStage (miss source), the I-cache arrays (write port) and the memory interface (request/response).

Parameters:
- ADDR_WIDTH, 32, physical address width.
- DATA_WIDTH, 32, memory beat width in bits.
- LINE_BEATS, 4, beats per I-cache line (power of two, >=2).
- INDEX_WIDTH, 6, I-cache set index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- missValid  in  1  fetch head lane valid and I-cache missed.
- missAddr  in  ADDR_WIDTH  physical fetch address of the missing group.
- flush  in  1  fetch-stage clear (mispredict/recovery).
- memReqValid  out  1  read request valid.
- memReqReady  in  1  memory accepts request.
- memReqAddr  out  ADDR_WIDTH  line-aligned request address.
- memRspValid  in  1  response beat valid (no backpressure).
- memRspData  in  DATA_WIDTH  response beat data.
- cacheWE  out  1  data-array write enable.
- cacheWIndex  out  INDEX_WIDTH  set index being filled.
- cacheWBeat  out  log2(LINE_BEATS)  beat slot within line.
- cacheWData  out  DATA_WIDTH  beat data.
- cacheTagWE  out  1  tag/valid write enable (last beat only).
- cacheTag  out  ADDR_WIDTH-INDEX_WIDTH-log2(LINE_BEATS*DATA_WIDTH/8)  tag written.
- refillDone  out  1  one-cycle completion pulse.
- busy  out  1  controller not IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, beat counter=0; all outputs 0.
- FSM states: IDLE, REQ, WAIT_DATA, DONE.
- IDLE: missValid=1 and flush=0 -> latch line-aligned missAddr, go to REQ. missValid ignored when flush=1.
- REQ: memReqValid=1, memReqAddr stable.
  - memReqReady=1 -> WAIT_DATA, counter=0.
  - flush=1 with no handshake that cycle -> IDLE, no request issued.
  - flush and ready in the same cycle -> the request counts as accepted; go to WAIT_DATA.
- WAIT_DATA: each memRspValid beat drives cacheWE=1 combinationally in the same cycle, with cacheWBeat=counter, cacheWData=memRspData and cacheWIndex/cacheTag from the latched address.
  - Counter increments per beat.
  - On the beat with counter=LINE_BEATS-1: cacheTagWE=1 and go to DONE.
  - flush during WAIT_DATA does not abort: all beats are absorbed and the line is installed. A sticky "cancelled" bit is set.
- DONE: one cycle. refillDone=1 unless cancelled; cancelled cleared; go to IDLE. missValid is ignored in DONE.
- Fetch sees a hit on the cycle after DONE, so no duplicate request is issued for the same line.
- memRspValid outside WAIT_DATA is ignored; no array write.
- Latency, zero-wait memory: miss to refillDone = 1 (REQ) + LINE_BEATS + 1 cycles minimum.
- busy=1 in REQ, WAIT_DATA and DONE.
- Exactly one outstanding request at any time.

Optional Feature:
- Macro: ICACHE_REFILL_PERF_EN.
- Defined: adds outputs perfRefillCount (32-bit, increments on each refillDone or cancelled completion) and perfMissCycles (32-bit, increments every cycle busy=1). Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package (FetchUnitTypes): IcRefillState enum, ICACHE_LINE_BEATS, ICACHE_INDEX_WIDTH, and IcacheIndexPath/IcacheTagPath typedefs.
- Add ToIcacheIndex/ToIcacheTag address-split functions reused by FetchStage.
- One natural sub-module: icache_refill_beat_counter, a beat counter with last-beat detect and clear.

Test Plan:
- Basic refill: missAddr=0x0000_1234, ready immediate, 4 back-to-back beats 0xA0..0xA3.
  -> memReqAddr=0x0000_1230.
  -> cacheWE four cycles, beats 0..3 with data A0..A3.
  -> cacheTagWE with beat 3; refillDone 1 cycle later; total 6 cycles.
- Request backpressure: memReqReady low 3 cycles.
  -> memReqValid/addr held stable 4 cycles; one handshake only.
- Flush in REQ: flush=1 at cycle 2 before ready.
  -> IDLE next cycle, no handshake, no cacheWE, no refillDone.
- Flush in WAIT_DATA after beat 1.
  -> remaining beats still written, cacheTagWE on beat 3, refillDone stays 0; perfRefillCount still +1 when enabled.
- Gapped beats (idle cycles between beats), then missValid held high through DONE.
  -> writes only on valid cycles; no second request issued.
- Async reset asserted mid WAIT_DATA.
  -> all outputs 0 immediately; a new miss after release starts at REQ with counter=0.
